mp3_pc_i2s_tx: RTL and testbench

I2S playback transmitter that sits directly downstream of the audio PLL. It runs on the PLL's 12.288 MHz output and gates itself on the PLL `locked` indication. It buffers stereo PCM samples from the decoder side in a small FIFO and serialises them to the audio codec as BCLK/LRCLK/DACDAT at 48 kHz, 32-bit slots, in standard I2S format.

---
 rtl/mp3_pc_audio_pkg.sv | 20 ++
 rtl/mp3_pc_audio_fifo.sv | 71 +++++++
 rtl/mp3_pc_i2s_tx.sv | 142 ++++++++++++++
 tb/tb_mp3_pc_i2s_tx.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_pc_audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mp3_pc_audio_pkg
// Description : Shared constants and types for the I2S playback path.
//               Fixed framing: 32-bit slots, 4 clk per BCLK, 256 clk per
//               stereo frame (48 kHz at a 12.288 MHz audio clock).
// Revision    : 1.0 - initial release
// ============================================================================
package mp3_pc_audio_pkg;

    localparam int SLOT_BITS        = 32;
    localparam int CLK_PER_BCLK     = 4;
    localparam int FRAME_CLKS       = 256;

    // Stereo word at the default 16-bit sample width: {left, right}.
    localparam int DEFAULT_SAMPLE_W = 16;
    typedef logic [2*DEFAULT_SAMPLE_W-1:0] stereo_word_t;

endpackage
`default_nettype wire

// File: rtl/mp3_pc_audio_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mp3_pc_audio_fifo
// Description : Synchronous FIFO with first-word-fall-through read data.
//               Pushes while full and pops while empty are ignored.
// Ports       : clk, reset_n (sync, active-low)
//               push/push_data  - write side
//               pop/pop_data    - read side, pop_data is the current head
//               level/full/empty- occupancy status (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module mp3_pc_audio_fifo
    import mp3_pc_audio_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL_LVL = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_level == c_FULL_LVL);
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    // Storage needs no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mp3_pc_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : mp3_pc_i2s_tx
// Description : I2S playback transmitter. Buffers stereo PCM in a FIFO and
//               serialises it as BCLK/LRCLK/DACDAT (48 kHz, 32-bit slots,
//               standard I2S one-BCLK data delay). Gated by PLL lock.
// Ports       : clk, reset_n      - audio clock, sync active-low reset
//               pll_locked, en    - run = en & synchronised pll_locked
//               s_data/s_valid/s_ready - stereo push ({L,R})
//               bclk/lrclk/dacdat - codec serial interface
//               fifo_level        - FIFO occupancy
//               underrun/underrun_clr - sticky empty-at-frame-load flag
// Revision    : 1.0 - initial release
// ============================================================================
module mp3_pc_i2s_tx
    import mp3_pc_audio_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        pll_locked,
    input  logic                        en,
    input  logic [2*SAMPLE_W-1:0]       s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        bclk,
    output logic                        lrclk,
    output logic                        dacdat,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underrun,
    input  logic                        underrun_clr
);

    localparam int         c_BCLK_SHIFT = $clog2(CLK_PER_BCLK);
    localparam int         c_SLOT_IDX_W = $clog2(SLOT_BITS);
    localparam logic [7:0] c_CNT_LAST   = 8'(FRAME_CLKS - 1);

    logic [1:0]              r_sync;
    logic                    w_run;
    logic [7:0]              r_cnt;
    logic [7:0]              w_cnt_next;
    logic                    w_frame_load;
    logic                    w_pop;
    logic                    w_fifo_empty;
    logic                    w_fifo_full;
    logic [2*SAMPLE_W-1:0]   w_head;
    logic [2*SAMPLE_W-1:0]   r_hold;
    logic                    r_bclk;
    logic                    r_lrclk;
    logic                    r_dacdat;
    logic                    r_underrun;
    logic [c_SLOT_IDX_W-1:0] w_slot_bit;
    logic                    w_in_slot;
    logic [SAMPLE_W-1:0]     w_chan;
    logic [5:0]              w_shift_amt;
    logic [SAMPLE_W-1:0]     w_shifted;

    mp3_pc_audio_fifo #(
        .WIDTH (2*SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (s_valid),
        .push_data (s_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .level     (fifo_level),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) r_sync <= 2'b00;
        else          r_sync <= {r_sync[0], pll_locked};
    end

    assign w_run        = en & r_sync[1];
    // Idle parks the counter at the last count so the first running edge
    // wraps to 0 and is itself a frame load.
    assign w_cnt_next   = w_run ? (r_cnt + 8'd1) : c_CNT_LAST;
    assign w_frame_load = w_run && (r_cnt == c_CNT_LAST);
    // The pop sees only the registered empty flag, so a same-cycle push into
    // an empty FIFO cannot rescue this frame.
    assign w_pop        = w_frame_load & ~w_fifo_empty;

    // Bit to present at the coming BCLK falling edge, judged from the count
    // the edge lands on. Slot bit b (1..SAMPLE_W) carries sample bit SAMPLE_W-b.
    always_comb begin
        w_slot_bit  = w_cnt_next[c_BCLK_SHIFT +: c_SLOT_IDX_W];
        w_chan      = w_cnt_next[7] ? r_hold[SAMPLE_W-1:0]
                                    : r_hold[2*SAMPLE_W-1:SAMPLE_W];
        w_in_slot   = ({1'b0, w_slot_bit} != 6'd0) &&
                      ({1'b0, w_slot_bit} <= 6'(SAMPLE_W));
        w_shift_amt = 6'(SAMPLE_W) - {1'b0, w_slot_bit};
        w_shifted   = w_chan >> w_shift_amt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt      <= c_CNT_LAST;
            r_bclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_dacdat   <= 1'b0;
            r_hold     <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_bclk  <= w_run & w_cnt_next[c_BCLK_SHIFT-1];
            r_lrclk <= w_run & w_cnt_next[7];

            if (!w_run) begin
                r_dacdat <= 1'b0;
            end else if (w_cnt_next[c_BCLK_SHIFT-1:0] == '0) begin
                r_dacdat <= w_in_slot & w_shifted[0];
            end

            // A stopped frame's sample is dropped, never replayed.
            if (!w_run) begin
                r_hold <= '0;
            end else if (w_frame_load) begin
                r_hold <= w_pop ? w_head : '0;
            end

            if (w_frame_load && w_fifo_empty) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign s_ready  = reset_n & ~w_fifo_full;
    assign bclk     = r_bclk;
    assign lrclk    = r_lrclk;
    assign dacdat   = r_dacdat;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_mp3_pc_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mp3_pc_i2s_tx
// Description : Self-checking bench for mp3_pc_i2s_tx. A frame-position
//               reference model (queue FIFO + position within the frame)
//               predicts every output each clk.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mp3_pc_i2s_tx;
    import mp3_pc_audio_pkg::*;

    localparam int SW    = 16;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset_n, pll_locked, en, s_valid, underrun_clr;
    stereo_word_t s_data;
    logic         s_ready, bclk, lrclk, dacdat, underrun;
    logic [2:0]   fifo_level;
    logic [8:0]   obs;

    always #5 clk = ~clk;

    mp3_pc_i2s_tx #(.SAMPLE_W(SW), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .en           (en),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .dacdat       (dacdat),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    assign obs = {bclk, lrclk, dacdat, underrun, s_ready, fifo_level};

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit          m_lk1 = 0, m_lk2 = 0, m_und = 0;
    int          m_pos = -1;              // position in frame, -1 = idle
    logic [31:0] m_cur = '0;              // sample playing this frame
    logic [31:0] m_q[$];                  // buffered samples

    // Advance one clk edge: the model consumes the inputs present at the edge.
    task automatic tick();
        bit run, acc, load_empty;
        @(posedge clk);
        if (!reset_n) begin
            m_lk1 = 0; m_lk2 = 0; m_pos = -1; m_cur = '0; m_und = 0;
            m_q.delete();
        end else begin
            run = en && m_lk2;
            acc = s_valid && (m_q.size() < DEPTH);
            load_empty = 0;
            if (run) begin
                m_pos = (m_pos + 1) % 256;
                if (m_pos == 0) begin
                    if (m_q.size() != 0) m_cur = m_q.pop_front();
                    else begin m_cur = '0; load_empty = 1; end
                end
            end else begin
                m_pos = -1;
                m_cur = '0;
            end
            if (load_empty)        m_und = 1;
            else if (underrun_clr) m_und = 0;
            if (acc) m_q.push_back(s_data);
            m_lk2 = m_lk1;
            m_lk1 = pll_locked;
        end
        #1;
    endtask

    // Expected {bclk,lrclk,dacdat,underrun,s_ready,fifo_level} from the model.
    function automatic logic [8:0] exp_vec();
        logic b, l, d;
        logic [15:0] ch;
        int p, sb;
        b = 0; l = 0; d = 0;
        if (m_pos >= 0) begin
            b  = ((m_pos / 2) % 2) == 1;
            l  = m_pos >= 128;
            p  = m_pos - (m_pos % 4);      // last BCLK falling edge
            sb = (p % 128) / 4;
            ch = (p >= 128) ? m_cur[15:0] : m_cur[31:16];
            if (sb >= 1 && sb <= SW) d = ch[SW - sb];
        end
        return {b, l, d, m_und, (reset_n && m_q.size() < DEPTH), 3'(m_q.size())};
    endfunction

    task automatic push_one(input logic [31:0] d);
        s_valid = 1; s_data = d;
        tick();
        s_valid = 0;
    endtask

    task automatic clear_underrun();
        underrun_clr = 1;
        tick();
        underrun_clr = 0;
    endtask

    task automatic test_reset();
        reset_n = 0; pll_locked = 1; en = 1; s_valid = 0; underrun_clr = 0; s_data = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (obs !== 9'b0) $display("FAIL reset_outputs: got %b want %b", obs, 9'b0);
            else n_pass++;
        end
        reset_n = 1;
        tick(); tick();
        n_checks++;
        if (underrun !== 1'b0) $display("FAIL pre_run_underrun: got %b want 0", underrun);
        else n_pass++;
        tick();
        n_checks++;
        if (underrun !== 1'b1) $display("FAIL first_frame_underrun: got %b want 1", underrun);
        else n_pass++;
        for (int i = 1; i < 256; i++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec() || dacdat !== 1'b0)
                $display("FAIL underrun_frame cnt=%0d: got %b want %b", i, obs, exp_vec());
            else n_pass++;
        end
        en = 0;
        tick();
    endtask

    task automatic test_pattern();
        logic [15:0] lbits, rbits;
        int other, rises, lr_high, sb;
        logic prev;
        clear_underrun();
        push_one(32'hA5A5_0F0F);
        n_checks++;
        if (fifo_level !== 3'd1) $display("FAIL pattern_level: got %0d want 1", fifo_level);
        else n_pass++;
        en = 1;
        lbits = '0; rbits = '0; other = 0; rises = 0; lr_high = 0; prev = bclk;
        for (int i = 0; i < 256; i++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL pattern cnt=%0d: got %b want %b", i, obs, exp_vec());
            else n_pass++;
            if (bclk && !prev) rises++;
            prev = bclk;
            if (lrclk) lr_high++;
            if (i % 4 == 2) begin
                sb = (i % 128) / 4;
                if (sb >= 1 && sb <= SW) begin
                    if (i < 128) lbits = {lbits[14:0], dacdat};
                    else         rbits = {rbits[14:0], dacdat};
                end else if (dacdat) other++;
            end
        end
        n_checks++;
        if (lbits !== 16'hA5A5) $display("FAIL left_bits: got %h want a5a5", lbits); else n_pass++;
        n_checks++;
        if (rbits !== 16'h0F0F) $display("FAIL right_bits: got %h want 0f0f", rbits); else n_pass++;
        n_checks++;
        if (other !== 0) $display("FAIL pad_bits: got %0d ones want 0", other); else n_pass++;
        n_checks++;
        if (rises !== 64) $display("FAIL bclk_rises: got %0d want 64", rises); else n_pass++;
        n_checks++;
        if (lr_high !== 128) $display("FAIL lrclk_high: got %0d want 128", lr_high); else n_pass++;
        en = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        clear_underrun();
        s_valid = 1;
        for (int i = 0; i < 5; i++) begin
            s_data = $urandom;
            tick();
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL b2b_push %0d: got %b want %b", i, obs, exp_vec());
            else n_pass++;
            if (i == 3) begin
                n_checks++;
                if (s_ready !== 1'b0 || fifo_level !== 3'd4)
                    $display("FAIL b2b_full: got ready=%b level=%0d want ready=0 level=4", s_ready, fifo_level);
                else n_pass++;
            end
        end
        s_valid = 0;
        en = 1;
        for (int i = 0; i < 4 * 256; i++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL b2b_play t=%0d: got %b want %b", i, obs, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (underrun !== 1'b0) $display("FAIL b2b_no_underrun: got %b want 0", underrun); else n_pass++;
        tick();
        n_checks++;
        if (underrun !== 1'b1) $display("FAIL b2b_fifth_underrun: got %b want 1", underrun); else n_pass++;
        en = 0;
        tick();
    endtask

    task automatic test_relock();
        clear_underrun();
        push_one($urandom);
        push_one($urandom);
        en = 1;
        for (int i = 0; i < 101; i++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL relock_pre t=%0d: got %b want %b", i, obs, exp_vec());
            else n_pass++;
        end
        pll_locked = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL relock_drop t=%0d: got %b want %b", i, obs, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if ({bclk, lrclk, dacdat} !== 3'b000) $display("FAIL unlock_quiet: got %b want 000", {bclk, lrclk, dacdat});
        else n_pass++;
        pll_locked = 1;
        for (int i = 0; i < 258; i++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL relock_play t=%0d: got %b want %b", i, obs, exp_vec());
            else n_pass++;
            if (i == 2) begin
                n_checks++;
                if (fifo_level !== 3'd0) $display("FAIL relock_pop: got level %0d want 0", fifo_level);
                else n_pass++;
            end
        end
        en = 0;
        tick();
    endtask

    task automatic test_same_cycle();
        clear_underrun();
        push_one($urandom);
        push_one($urandom);
        en = 1; s_valid = 1; s_data = $urandom;
        tick();
        s_valid = 0;
        n_checks++;
        if (fifo_level !== 3'd2) $display("FAIL push_pop_level: got %0d want 2", fifo_level); else n_pass++;
        underrun_clr = 1;
        for (int i = 0; i < 767; i++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL same_cycle t=%0d: got %b want %b", i, obs, exp_vec());
            else n_pass++;
        end
        tick();
        n_checks++;
        if (underrun !== 1'b1) $display("FAIL set_beats_clear: got %b want 1", underrun); else n_pass++;
        underrun_clr = 0;
        en = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        s_valid = 1;
        for (int i = 0; i < 4; i++) begin
            s_data = $urandom;
            tick();
        end
        s_valid = 0;
        en = 1;
        for (int i = 0; i < 60; i++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL mid_run t=%0d: got %b want %b", i, obs, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (fifo_level !== 3'd3) $display("FAIL mid_level: got %0d want 3", fifo_level); else n_pass++;
        reset_n = 0;
        #1;
        n_checks++;
        if (s_ready !== 1'b0) $display("FAIL ready_in_reset: got %b want 0", s_ready); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (obs !== 9'b0) $display("FAIL reset_mid_frame t=%0d: got %b want %b", i, obs, 9'b0);
            else n_pass++;
        end
        reset_n = 1;
        #1;
        n_checks++;
        if (s_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", s_ready); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL post_reset t=%0d: got %b want %b", i, obs, exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_back_to_back();
        test_relock();
        test_same_cycle();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
